// File: rtl/pwm_capture_pkg.sv
// Register map, bit positions, FSM encoding and counter helper shared by the
// PWM capture block and its sub-modules.
package pwm_capture_pkg;

    localparam int CSR_AW   = 5;
    localparam int CSR_DW   = 8;
    localparam int CNT_W    = 16;
    localparam int NUM_REGS = 6;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_PERIOD_L = 3'd2;
    localparam logic [2:0] OFF_PERIOD_H = 3'd3;
    localparam logic [2:0] OFF_HIGH_L   = 3'd4;
    localparam logic [2:0] OFF_HIGH_H   = 3'd5;

    localparam int CTRL_EN_BIT      = 7;
    localparam int CTRL_IRQ_EN_BIT  = 6;
    localparam int CTRL_INV_BIT     = 0;
    localparam int STATUS_VALID_BIT = 7;
    localparam int STATUS_OVF_BIT   = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    typedef struct packed {
        logic en;
        logic irq_en;
        logic inv;
    } ctrl_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with optional inversion
// and a single-cycle rising-edge strobe on the (possibly inverted) level.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic inv,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   lvl_dly_q;
    logic                   lvl_dly_d;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], async_in};
        lvl_dly_d = lvl;
    end

    assign lvl  = sync_q[SYNC_STAGES-1] ^ inv;
    assign rise = lvl & ~lvl_dly_q;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, just like real hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            lvl_dly_q <= lvl_dly_d;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM / tach capture: measures period and high time of pwm_in in sample_ce
// units and exposes the result through the byte-wide CSR bus.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter logic [CSR_AW-1:0] BASE_ADDR   = 5'h0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CSR_AW-1:0] csr_a,
    input  logic [CSR_DW-1:0] csr_di,
    input  logic              csr_we,
    output logic [CSR_DW-1:0] csr_do,
    input  logic              sample_ce,
    input  logic              pwm_in,
    output logic              irq
);

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;

    logic              lvl;
    logic              rise;
    logic [CSR_AW-1:0] offset;
    logic              in_range;
    logic [2:0]        reg_sel;
    logic              ctrl_wr;
    logic              status_wr;
    logic              clr_valid;
    logic              clr_ovf;
    logic              latch_ok;
    logic              set_valid;
    logic              set_ovf;
    logic [CNT_W-1:0]  reload;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .async_in(pwm_in),
        .inv     (ctrl_q.inv),
        .lvl     (lvl),
        .rise    (rise)
    );

    assign offset    = csr_a - BASE_ADDR;
    assign in_range  = (offset < CSR_AW'(NUM_REGS));
    assign reg_sel   = offset[2:0];
    assign ctrl_wr   = csr_we && in_range && (reg_sel == OFF_CTRL);
    assign status_wr = csr_we && in_range && (reg_sel == OFF_STATUS);
    assign clr_valid = status_wr && csr_di[STATUS_VALID_BIT];
    assign clr_ovf   = status_wr && csr_di[STATUS_OVF_BIT];
    assign reload    = {{(CNT_W-1){1'b0}}, sample_ce};

    // A result only lands when software has consumed the previous one, so a
    // 16-bit pair is never overwritten between its two byte reads.
    assign latch_ok  = ~valid_q | clr_valid;

    // Reserved CTRL/STATUS write bits are intentionally ignored.
    logic unused_csr_di;
    assign unused_csr_di = ^csr_di[5:1];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        set_valid    = 1'b0;
        set_ovf      = 1'b0;

        if (!ctrl_q.en) begin
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    if (rise) begin
                        state_d      = MEASURE;
                        period_cnt_d = reload;
                        high_cnt_d   = reload;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (latch_ok) begin
                            period_d  = period_cnt_q;
                            high_d    = high_cnt_q;
                            set_valid = 1'b1;
                        end
                        period_cnt_d = reload;
                        high_cnt_d   = reload;
                    end else if (period_cnt_q == CNT_MAX) begin
                        set_ovf      = 1'b1;
                        state_d      = IDLE;
                        period_cnt_d = '0;
                        high_cnt_d   = '0;
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q, sample_ce);
                        high_cnt_d   = sat_inc(high_cnt_q, sample_ce & lvl);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_wr) begin
            ctrl_d.en     = csr_di[CTRL_EN_BIT];
            ctrl_d.irq_en = csr_di[CTRL_IRQ_EN_BIT];
            ctrl_d.inv    = csr_di[CTRL_INV_BIT];
        end
        // Set has priority over a same-cycle write-one-to-clear.
        valid_d = set_valid | (valid_q & ~clr_valid);
        ovf_d   = set_ovf   | (ovf_q   & ~clr_ovf);
        irq_d   = ctrl_q.irq_en & (valid_q | ovf_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        csr_do = '0;
        if (in_range) begin
            case (reg_sel)
                OFF_CTRL: begin
                    csr_do[CTRL_EN_BIT]     = ctrl_q.en;
                    csr_do[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
                    csr_do[CTRL_INV_BIT]    = ctrl_q.inv;
                end
                OFF_STATUS: begin
                    csr_do[STATUS_VALID_BIT] = valid_q;
                    csr_do[STATUS_OVF_BIT]   = ovf_q;
                end
                OFF_PERIOD_L: csr_do = period_q[7:0];
                OFF_PERIOD_H: csr_do = period_q[15:8];
                OFF_HIGH_L:   csr_do = high_q[7:0];
                OFF_HIGH_H:   csr_do = high_q[15:8];
                default:      csr_do = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: a time-stamped edge model
// predicts each CSR read, and a negedge monitor compares in order.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam logic [4:0] BASE       = 5'h10;
    localparam logic [2:0] R_CTRL     = 3'd0;
    localparam logic [2:0] R_STATUS   = 3'd1;
    localparam logic [2:0] R_PERIOD_L = 3'd2;
    localparam logic [2:0] R_PERIOD_H = 3'd3;
    localparam logic [2:0] R_HIGH_L   = 3'd4;
    localparam logic [2:0] R_HIGH_H   = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] csr_a = '0;
    logic [7:0] csr_di = '0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       sample_ce = 1'b1;
    logic       pwm_in = 1'b0;
    logic       irq;

    pwm_capture #(
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .csr_a    (csr_a),
        .csr_di   (csr_di),
        .csr_we   (csr_we),
        .csr_do   (csr_do),
        .sample_ce(sample_ce),
        .pwm_in   (pwm_in),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [7:0] exp;
        bit         is_irq;
    } exp_t;

    exp_t exp_q[$];
    logic rd_strobe = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_extra = 0;

    // Monitor: pops the expected value for every read the driver presents.
    always @(negedge clk) begin
        if (rd_strobe) begin
            if (exp_q.size() == 0) begin
                n_total <= n_total + 1;
                $display("FAIL scoreboard_underflow: got a read with no expectation queued");
            end else begin
                exp_t       e;
                logic [7:0] act;
                e   = exp_q.pop_front();
                act = e.is_irq ? {7'b0, irq} : csr_do;
                n_total <= n_total + 1;
                if (act === e.exp) n_pass <= n_pass + 1;
                else $display("FAIL %s: got 8'h%02h expected 8'h%02h (cycle %0d)",
                              e.name, act, e.exp, cyc);
            end
        end
    end

    // Reference model: time-stamped active edges in units of clk (sample_ce=1).
    bit          m_en, m_irq_en, m_inv, m_valid, m_ovf, m_armed, pwm_lvl;
    logic [15:0] m_period, m_high;
    int          m_t_rise, m_t_fall;

    task automatic model_reset();
        m_en = 0; m_irq_en = 0; m_inv = 0; m_valid = 0; m_ovf = 0; m_armed = 0;
        m_period = '0; m_high = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_pwm(input bit v, input bit clr_same);
        bit old_act, new_act;
        if (v == pwm_lvl) return;
        old_act = pwm_lvl ^ m_inv;
        new_act = v ^ m_inv;
        pwm_lvl = v;
        pwm_in  = v;
        if (m_en) begin
            if (new_act && !old_act) begin
                if (m_armed && (!m_valid || clr_same)) begin
                    m_period = 16'(cyc - m_t_rise);
                    m_high   = 16'(m_t_fall - m_t_rise);
                    m_valid  = 1;
                end
                m_armed  = 1;
                m_t_rise = cyc;
            end else if (!new_act && old_act) begin
                m_t_fall = cyc;
            end
        end
    endtask

    task automatic csr_write(input logic [2:0] off, input logic [7:0] d, input bit upd);
        csr_a  = BASE + 5'(off);
        csr_di = d;
        csr_we = 1'b1;
        if (upd) begin
            if (off == R_CTRL) begin
                m_en = d[7]; m_irq_en = d[6]; m_inv = d[0];
                if (!m_en) m_armed = 0;
            end else if (off == R_STATUS) begin
                if (d[7]) m_valid = 0;
                if (d[6]) m_ovf = 0;
            end
        end
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name,
                      input bit is_irq);
        exp_t e;
        csr_a    = a;
        e.name   = name;
        e.exp    = exp;
        e.is_irq = is_irq;
        exp_q.push_back(e);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic check_results(input string tag);
        rd(BASE + 5'(R_CTRL),     {m_en, m_irq_en, 5'b0, m_inv}, {tag, "_ctrl"}, 0);
        rd(BASE + 5'(R_STATUS),   {m_valid, m_ovf, 6'b0},        {tag, "_status"}, 0);
        rd(BASE + 5'(R_PERIOD_L), m_period[7:0],                 {tag, "_period_l"}, 0);
        rd(BASE + 5'(R_PERIOD_H), m_period[15:8],                {tag, "_period_h"}, 0);
        rd(BASE + 5'(R_HIGH_L),   m_high[7:0],                   {tag, "_high_l"}, 0);
        rd(BASE + 5'(R_HIGH_H),   m_high[15:8],                  {tag, "_high_h"}, 0);
        rd(BASE, {7'b0, m_irq_en & (m_valid | m_ovf)},           {tag, "_irq"}, 1);
    endtask

    // One pwm_in period starting with a rising edge; checks sit in the low
    // phase, well clear of both edges. Requires p - h >= 16.
    task automatic drive_pulse(input int h, input int p, input bit chk, input bit clr,
                               input bit clr_at_rise, input string tag);
        int t0;
        t0 = cyc;
        set_pwm(1, clr_at_rise);
        if (clr_at_rise) begin
            tick();
            tick();
            csr_write(R_STATUS, 8'h80, 0);
        end
        wait_until(t0 + h);
        set_pwm(0, 0);
        repeat (4) tick();
        if (chk) check_results(tag);
        if (clr) csr_write(R_STATUS, 8'h80, 1);
        wait_until(t0 + p);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        model_reset();
        pwm_lvl = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_results("reset");

        // Basic 30/100 measurement.
        csr_write(R_CTRL, 8'h80, 1);
        repeat (6) tick();
        drive_pulse(30, 100, 1, 0, 0, "basic_first");
        drive_pulse(30, 100, 1, 0, 0, "basic_second");
        drive_pulse(30, 100, 1, 0, 0, "basic_third");

        // Freeze while valid, then release with W1C, then W1C on the rise cycle.
        drive_pulse(15, 50, 1, 0, 0, "freeze_a");
        drive_pulse(15, 50, 1, 1, 0, "freeze_b");
        drive_pulse(15, 50, 1, 0, 0, "w1c_latch");
        drive_pulse(10, 40, 1, 0, 0, "pre_race");
        drive_pulse(10, 40, 1, 0, 1, "race");
        drive_pulse(10, 40, 1, 0, 0, "post_race");

        // Randomized periods with random consumption of results.
        for (int i = 0; i < 10; i++) begin
            int h, p;
            h = $urandom_range(1, 60);
            p = h + $urandom_range(16, 80);
            drive_pulse(h, p, 1, 1'($urandom_range(0, 1)), 0, "rnd");
        end

        // Stall and overflow with interrupt enabled.
        csr_write(R_CTRL, 8'hC0, 1);
        repeat (4) tick();
        drive_pulse(30, 100, 1, 1, 0, "pre_stall");
        repeat (70000) tick();
        if (m_armed && (cyc - m_t_rise) > 65540) begin
            m_ovf   = 1;
            m_armed = 0;
        end
        csr_write(R_STATUS, 8'h80, 1);
        repeat (3) tick();
        check_results("stall");
        drive_pulse(30, 100, 1, 0, 0, "resume_first");
        drive_pulse(30, 100, 1, 0, 0, "resume_second");
        csr_write(R_STATUS, 8'hC0, 1);
        repeat (3) tick();
        check_results("clr_all");

        // Inverted measurement: the low phase is reported as high time.
        csr_write(R_CTRL, 8'h01, 1);
        repeat (6) tick();
        csr_write(R_STATUS, 8'hC0, 1);
        csr_write(R_CTRL, 8'h81, 1);
        repeat (6) tick();
        drive_pulse(30, 100, 1, 0, 0, "inv_first");
        drive_pulse(30, 100, 1, 0, 0, "inv_second");

        // Asynchronous reset mid-period.
        set_pwm(1, 0);
        repeat (10) tick();
        rst = 1'b1;
        model_reset();
        check_results("rst_mid");
        rst = 1'b0;
        set_pwm(0, 0);
        repeat (4) tick();

        // Disable mid-period, out-of-range reads, write-zero to STATUS.
        csr_write(R_CTRL, 8'h80, 1);
        repeat (6) tick();
        drive_pulse(30, 100, 0, 0, 0, "dis_a");
        drive_pulse(30, 100, 0, 0, 0, "dis_b");
        set_pwm(1, 0);
        repeat (10) tick();
        csr_write(R_CTRL, 8'h00, 1);
        repeat (3) tick();
        check_results("disabled");
        rd(5'h0F, 8'h00, "oor_below", 0);
        rd(5'h16, 8'h00, "oor_above", 0);
        rd(5'h1F, 8'h00, "oor_top", 0);
        csr_write(R_STATUS, 8'h00, 1);
        set_pwm(0, 0);
        repeat (20) tick();
        set_pwm(1, 0);
        repeat (20) tick();
        set_pwm(0, 0);
        repeat (5) tick();
        check_results("dis_hold");

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_extra = 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total + n_extra);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures period and high time of an external PWM or fan-tach input (pwm_in) in units of sample_ce pulses. Results are exposed through the same byte-wide CSR bus as the other sl28 CPLD peripherals. It is the receive-side counterpart of the PWM generator and sits beside it on the CSR decoder. It raises a level interrupt on a new result or on a stalled input.

Parameters:
BASE_ADDR, 5'h0, CSR base address; block decodes BASE_ADDR+0..+5.
SYNC_STAGES, 2, synchronizer depth for pwm_in (>=2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
csr_a  in  5  CSR address
csr_di  in  8  CSR write data
csr_we  in  1  CSR write strobe, one clk
csr_do  out  8  CSR read data, combinational from csr_a; 0 outside own range
sample_ce  in  1  measurement timebase enable, one-clk pulses
pwm_in  in  1  asynchronous input to measure
irq  out  1  level interrupt

Behaviour:
- Reset is asynchronous and active-high on rst; clk is the only clock.
- Register map, offsets from BASE_ADDR:
  - +0 CTRL rw: [7] en, [6] irq_en, [0] inv (measure the low phase as "high"); other bits read 0.
  - +1 STATUS w1c: [7] valid, [6] ovf; other bits read 0.
  - +2 PERIOD_L, +3 PERIOD_H ro.
  - +4 HIGH_L, +5 HIGH_H ro.
- Reset values: every register 0; irq=0; csr_do=0 for addresses outside the block's range; FSM in IDLE; counters 0.
- Input path:
  - pwm_in passes through SYNC_STAGES flops, then is XORed with inv to give lvl.
  - lvl_d is lvl delayed by one clk; rise = lvl & ~lvl_d.
  - With SYNC_STAGES=2, a pwm_in rising edge produces rise exactly 3 clk later.
- Counters: period_cnt and high_cnt, 16 bits each, saturating at 16'hFFFF.
  - period_cnt increments on sample_ce.
  - high_cnt increments on sample_ce & lvl.
- FSM IDLE:
  - Counters held at 0.
  - en & rise -> MEASURE, with period_cnt<=sample_ce and high_cnt<=sample_ce.
- FSM MEASURE, on rise:
  - If latch_ok, then PERIOD<=period_cnt, HIGH<=high_cnt, valid<=1.
  - latch_ok = ~valid | (csr_we to STATUS with di[7]=1 in the same cycle).
  - Counters reload as in IDLE->MEASURE.
  - If latch_ok is false, the measurement is discarded and the previous result stays frozen, so software never reads a torn 16-bit value.
- FSM MEASURE, period_cnt reaching 16'hFFFF without rise:
  - ovf<=1 (sticky), FSM->IDLE, PERIOD/HIGH unchanged.
  - The next rise restarts measurement.
- en cleared: FSM->IDLE next clk, counters cleared; valid, ovf, PERIOD and HIGH are retained.
- w1c: writing 1 clears the bit; writing 0 has no effect.
- Simultaneous set and clear of the same status bit: set wins.
- irq = irq_en & (valid | ovf), registered, so it follows the status bits by one clk.
- HIGH <= PERIOD always holds for a latched pair.
- HIGH=0 means the input was high for less than one sample.
- rst asserted mid-measurement: everything returns immediately to reset values.

Decomposition:
- Shared register-map include holds:
  - register offsets: CTRL, STATUS, PERIOD_L/H, HIGH_L/H;
  - CTRL/STATUS bit positions;
  - the FSM state encoding: IDLE=0, MEASURE=1.
- One natural sub-module: sync_edge, a parameterised SYNC_STAGES synchronizer plus rise detector, reusable for other async CPLD inputs.

Test Plan:
- Setup for all scenarios: sample_ce=1 every clk.
- Basic measurement: en=1; pwm_in period 100 clk, high 30 clk.
  - Required: after the second rise, PERIOD=16'h0064, HIGH=16'h001E, valid=1.
  - Rise-to-rise latency is 3 clk from each pwm_in edge.
- Freeze and W1C: leave valid set and change pwm_in to period 50.
  - Required: PERIOD stays 0x0064.
  - Write STATUS=8'h80: the next period latches 0x0032.
  - Write STATUS=8'h80 in the exact cycle of rise: the new value latches and valid stays 1.
- Stall: hold pwm_in=0 for 70000 clk.
  - Required: ovf=1 after period_cnt reaches 0xFFFF; PERIOD unchanged; with irq_en=1, irq=1.
  - After the input resumes, a valid result appears after two rises.
- Inversion and first edge: inv=1 with 30/100 input.
  - Required: HIGH=0x0046.
  - The first rise after en=1 produces no result.
- Reset and disable:
  - rst pulse mid-period: all CSRs read 0 and irq=0 immediately.
  - en=0 mid-period: PERIOD/HIGH retained; reads outside BASE_ADDR+0..+5 return 8'h00.
